debounced_logic_gate: RTL and testbench

//  Next-generation switch-to-LED logic gate for the board projects.
//  NUM_INPUTS raw switch inputs are each debounced independently, then reduced by a
//  run-time selectable operator (AND/OR/XOR/NAND). The result drives one registered LED.
//  A one-cycle change pulse is available for downstream counters/displays.

---
 rtl/debounced_logic_gate.sv | 81 ++++++++
 tb/tb_debounced_logic_gate.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/debounced_logic_gate.sv
// Per-channel switch debouncer feeding a mode-selectable reduction gate.
// The gate result is registered onto the LED, with a one-cycle pulse on every LED change.
module debounced_logic_gate #(
    parameter int unsigned NUM_INPUTS     = 2,
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [NUM_INPUTS-1:0] i_Switch,
    input  logic [1:0]            i_Mode,
    output logic [NUM_INPUTS-1:0] o_Switch_Db,
    output logic                  o_LED,
    output logic                  o_Toggle
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_LIMIT - 1);

    logic [NUM_INPUTS-1:0] db;

    for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_chan
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            db_q, db_d;

        // Counter clears whenever input agrees with the debounced level, so a glitch restarts it.
        always_comb begin
            cnt_d = '0;
            db_d  = db_q;
            if (i_Switch[n] != db_q) begin
                if (cnt_q == CntLast) begin
                    db_d = i_Switch[n];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge i_Clk) begin
            if (i_Rst) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                db_q  <= db_d;
            end
        end

        assign db[n] = db_q;
    end

    logic gate_d;
    logic led_q, toggle_q, first_q;

    always_comb begin
        gate_d = 1'b0;
        unique case (i_Mode)
            2'b00: gate_d = &db;
            2'b01: gate_d = |db;
            2'b10: gate_d = ^db;
            2'b11: gate_d = ~&db;
        endcase
    end

    // first_q masks the pulse from the initial post-reset evaluation (e.g. NAND -> 1).
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            led_q    <= 1'b0;
            toggle_q <= 1'b0;
            first_q  <= 1'b1;
        end else begin
            led_q    <= gate_d;
            toggle_q <= (gate_d != led_q) && !first_q;
            first_q  <= 1'b0;
        end
    end

    assign o_Switch_Db = db;
    assign o_LED       = led_q;
    assign o_Toggle    = toggle_q;

endmodule

// File: tb/tb_debounced_logic_gate.sv
// Directed bench for debounced_logic_gate: expected LED toggles are queued by the stimulus
// and matched by a monitor against every o_Toggle pulse; level checks are made inline.
module tb_debounced_logic_gate;

    localparam int unsigned NumInputs = 3;
    localparam int unsigned Limit     = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NumInputs-1:0] sw;
    logic [1:0]           mode;
    logic [NumInputs-1:0] db;
    logic                 led;
    logic                 toggle;

    int tests = 0;
    int fails = 0;
    int edges = 0;

    typedef struct {
        int   edge_n;
        logic led;
    } exp_t;

    exp_t exp_q[$];

    debounced_logic_gate #(
        .NUM_INPUTS    (NumInputs),
        .DEBOUNCE_LIMIT(Limit)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Switch   (sw),
        .i_Mode     (mode),
        .o_Switch_Db(db),
        .o_LED      (led),
        .o_Toggle   (toggle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expect a toggle pulse (with the new LED level) visible after edge number e.
    task automatic expect_toggle(input int e, input logic l);
        exp_t x;
        x.edge_n = e;
        x.led    = l;
        exp_q.push_back(x);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (toggle === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_toggle: got pulse at edge %0d expected none", edges);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("toggle_edge", edges, x.edge_n);
                check("toggle_led", {31'b0, led}, {31'b0, x.led});
            end
        end
    end

    initial begin
        logic [2:0] prev;
        int         n0;

        // Reset with switches high
        rst  = 1'b1;
        sw   = 3'b111;
        mode = 2'b00;
        tick(2);
        check("rst_db", {29'b0, db}, 32'h0);
        check("rst_led", {31'b0, led}, 32'h0);
        check("rst_toggle", {31'b0, toggle}, 32'h0);
        sw  = 3'b000;
        rst = 1'b0;
        tick(2);

        // Glitch: 3 edges high then back low
        sw = 3'b001;
        tick(3);
        check("glitch_db_mid", {29'b0, db}, 32'h0);
        sw = 3'b000;
        tick(6);
        check("glitch_db", {29'b0, db}, 32'h0);

        // AND truth table
        prev = 3'b000;
        for (int p = 0; p < 8; p++) begin
            sw = 3'(p);
            n0 = edges;
            if ((p == 7) != (prev == 3'b111)) expect_toggle(n0 + 5, p == 7);
            tick(3);
            check("and_db_hold", {29'b0, db}, {29'b0, prev});
            tick(1);
            check("and_db_commit", {29'b0, db}, p);
            check("and_led_pre", {31'b0, led}, {31'b0, prev == 3'b111});
            tick(1);
            check("and_led", {31'b0, led}, {31'b0, p == 7});
            tick(5);
            prev = 3'(p);
        end

        // Mode sweep with 101 settled (111 -> 101 gives the falling pulse)
        sw = 3'b101;
        expect_toggle(edges + 5, 1'b0);
        tick(10);
        check("mode_and", {31'b0, led}, 32'h0);
        mode = 2'b01;
        expect_toggle(edges + 1, 1'b1);
        tick(1);
        check("mode_or", {31'b0, led}, 32'h1);
        mode = 2'b10;
        expect_toggle(edges + 1, 1'b0);
        tick(1);
        check("mode_xor", {31'b0, led}, 32'h0);
        mode = 2'b11;
        expect_toggle(edges + 1, 1'b1);
        tick(1);
        check("mode_nand", {31'b0, led}, 32'h1);
        mode = 2'b00;
        expect_toggle(edges + 1, 1'b0);
        tick(1);
        check("mode_back_and", {31'b0, led}, 32'h0);

        // Simultaneous change on all channels
        sw = 3'b000;
        tick(10);
        sw = 3'b111;
        n0 = edges;
        expect_toggle(n0 + 5, 1'b1);
        tick(3);
        check("simul_db_hold", {29'b0, db}, 32'h0);
        tick(1);
        check("simul_db", {29'b0, db}, 32'h7);
        check("simul_led_pre", {31'b0, led}, 32'h0);
        tick(1);
        check("simul_led", {31'b0, led}, 32'h1);
        tick(5);

        // Reset in the middle of a count
        sw = 3'b000;
        expect_toggle(edges + 5, 1'b0);
        tick(10);
        sw = 3'b010;
        tick(2);
        rst = 1'b1;
        tick(1);
        check("midrst_db", {29'b0, db}, 32'h0);
        rst = 1'b0;
        tick(2);
        check("midrst_db_e2", {29'b0, db}, 32'h0);
        tick(1);
        check("midrst_db_e3", {29'b0, db}, 32'h0);
        tick(1);
        check("midrst_db_e4", {29'b0, db}, 32'h2);
        tick(3);

        // NAND mode straight out of reset: LED goes high with no pulse
        rst  = 1'b1;
        mode = 2'b11;
        sw   = 3'b000;
        tick(2);
        check("nand_rst_led", {31'b0, led}, 32'h0);
        rst = 1'b0;
        tick(1);
        check("nand_led", {31'b0, led}, 32'h1);
        check("nand_toggle", {31'b0, toggle}, 32'h0);
        tick(3);

        check("pending_toggles", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
